if_prefetch_stage: RTL and testbench
====================================

Name: if_prefetch_stage

Overview:
Parametrised instruction-fetch stage with a prefetch queue. It replaces the single-entry fetch/hold scheme with a DEPTH-entry FIFO of fetched {pc, instr} pairs. It issues one read per cycle to a synchronous instruction SRAM that has a fixed 1-cycle read latency, and discards stale responses after a redirect. It sits between the instruction memory and the IF/ID boundary. It supplies ID with pc, pc+4, instr and a valid flag; downstream hazard stalls are absorbed by the queue instead of by re-fetching.

Parameters:
XLEN, 32, data/PC width
IADDR_W, 14, word-address width to instruction SRAM (byte PC bits [IADDR_W+1:2])
DEPTH, 4, prefetch queue entries; legal range 2..16
RESET_PC, 0, PC fetched first after reset (word-aligned)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
redirect  in  1  branch/jump taken; flush and refetch from redirect_pc
redirect_pc  in  XLEN  target PC; bits[1:0] ignored, treated as 0
stall  in  1  downstream hazard; ID does not consume this cycle
imem_req  out  1  read enable to instruction SRAM
imem_addr  out  IADDR_W  word address, equal to fetch_pc[IADDR_W+1:2]
imem_rdata  in  XLEN  read data, valid the cycle after imem_req
valid_out  out  1  head entry presented to ID
pc_out  out  XLEN  PC of head entry; 0 when !valid_out
pc4_out  out  XLEN  pc_out+4; 0 when !valid_out
instr_out  out  XLEN  head instruction; 32'd0 (bubble) when !valid_out
count_out  out  $clog2(DEPTH+1)  occupied entries, for debug/perf

Behaviour:
- State:
  - fetch_pc
  - queue storage: DEPTH x {pc, instr}, with rd/wr pointers wrapping modulo DEPTH
  - count
  - inflight flag and inflight_pc for the single outstanding read
- Reset: fetch_pc=RESET_PC, count=0, pointers=0, inflight=0. All outputs 0 during and after reset until the first entry is written; imem_req=0 while rst.
- pop = valid_out & !stall & !redirect.
- Issue:
  - imem_req = !rst & !redirect & (count + inflight - pop < DEPTH).
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps modulo 2^XLEN).
- Response: when inflight=1 (set last cycle), imem_rdata is written at wr_ptr with inflight_pc. inflight clears unless a new issue occurs the same cycle.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Credit rule: the queue never overflows. A push into a full queue is impossible by construction; the bench checks this with an assertion.
- Outputs are driven from the head entry (rd_ptr) when count>0, otherwise zeros. No bypass: a response becomes visible on valid_out the cycle after it is written.
- Redirect (priority over stall and rst-free operation):
  - same cycle: count<=0, pointers<=0, inflight<=0 (the response arriving next cycle is dropped), fetch_pc<=redirect_pc&~3, no issue, no pop.
  - Next cycle: issue from the target. The cycle after: write. The cycle after that: valid_out=1.
  - Redirect-to-first-valid latency is 3 cycles.
- Redirect while stall=1: flush still happens.
- Redirect while the queue is empty and a read is in flight: the in-flight data is discarded.
- Steady state with stall=0: one instruction per cycle after the initial 3-cycle fill.
- Stall held: the queue fills to DEPTH and then imem_req=0. Outputs hold the head entry stable. On release, one entry is popped per cycle with no gap.
- rst mid-operation: takes effect at the next edge regardless of redirect/stall. The queue and the in-flight read are discarded.

Test Plan:
- Reset release, stall=0, redirect=0, memory word[n]=n+0x100: valid_out first high 2 cycles after rst deasserts; pc_out 0,4,8,... with instr_out 0x100,0x101,... one per cycle, no gaps.
- stall=1 for 10 cycles mid-stream (DEPTH=4): imem_req drops after count_out=4; outputs frozen at the same pc. After release, pcs continue consecutively with no loss or duplicate.
- redirect=1, redirect_pc=0x43 while queue holds 3 entries and a read is in flight: count_out=0 next cycle; the next valid pc_out=0x40 exactly 3 cycles later; no pre-redirect instruction appears.
- Redirect and stall asserted together, then back-to-back redirects on consecutive cycles (0x80, then 0xC0): only the 0xC0 stream appears.
- fetch_pc near 0xFFFFFFFC: pc_out wraps to 0; imem_addr uses bits[IADDR_W+1:2]. Rerun with DEPTH=2 and DEPTH=16: full throughput and no overflow assertion.
- rst asserted for 1 cycle mid-stream with entries queued: valid_out=0 and outputs 0 next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_stage_if.sv
// Handshake bundle between the prefetch stage, the instruction SRAM and ID.
// The master side is the fetch stage itself; the slave side is its environment.
interface if_prefetch_stage_if #(
    parameter int XLEN    = 32,
    parameter int IADDR_W = 14,
    parameter int DEPTH   = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    // Control from the pipeline
    logic               redirect;
    logic [XLEN-1:0]    redirect_pc;
    logic               stall;

    // Instruction SRAM port
    logic               imem_req;
    logic [IADDR_W-1:0] imem_addr;
    logic [XLEN-1:0]    imem_rdata;

    // IF/ID boundary
    logic               valid_out;
    logic [XLEN-1:0]    pc_out;
    logic [XLEN-1:0]    pc4_out;
    logic [XLEN-1:0]    instr_out;
    logic [CW-1:0]      count_out;

    modport master (
        input  redirect, redirect_pc, stall, imem_rdata,
        output imem_req, imem_addr, valid_out, pc_out, pc4_out, instr_out, count_out
    );

    modport slave (
        output redirect, redirect_pc, stall, imem_rdata,
        input  imem_req, imem_addr, valid_out, pc_out, pc4_out, instr_out, count_out
    );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue of {pc, instr}.
// One read per cycle is issued to a 1-cycle-latency SRAM while credit exists;
// a redirect flushes the queue and drops the single in-flight response.
module if_prefetch_stage #(
    parameter int              XLEN     = 32,
    parameter int              IADDR_W  = 14,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    if_prefetch_stage_if.master bus
);
    localparam int              CW         = $clog2(DEPTH + 1);
    localparam int              PW         = $clog2(DEPTH);
    localparam logic [CW:0]     DEPTH_W    = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]   PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PTR_LAST) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    // Architectural state
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] pc_mem_r    [DEPTH];
    logic [XLEN-1:0] instr_mem_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic            inflight_r;
    logic [XLEN-1:0] inflight_pc_r;

    // Per-cycle decisions
    logic            head_valid_s;
    logic [XLEN-1:0] head_pc_s;
    logic [XLEN-1:0] head_pc4_s;
    logic [XLEN-1:0] head_instr_s;
    logic            pop_s;
    logic            push_s;
    logic            issue_s;
    logic [CW:0]     occ_s;

    // Select the head entry for ID; an empty queue presents an all-zero bubble.
    always_comb begin
        head_valid_s = (count_r != {CW{1'b0}});
        if (head_valid_s) begin
            head_pc_s    = pc_mem_r[rd_ptr_r];
            head_pc4_s   = pc_mem_r[rd_ptr_r] + PC_STEP;
            head_instr_s = instr_mem_r[rd_ptr_r];
        end else begin
            head_pc_s    = {XLEN{1'b0}};
            head_pc4_s   = {XLEN{1'b0}};
            head_instr_s = {XLEN{1'b0}};
        end
    end

    // Decide pop, push and issue. A new read is only sent when the entry it
    // will occupy next cycle is guaranteed free, counting the read in flight.
    always_comb begin
        pop_s   = head_valid_s & ~bus.stall & ~bus.redirect;
        push_s  = inflight_r & ~bus.redirect;
        occ_s   = {1'b0, count_r} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
        issue_s = ~rst & ~bus.redirect & (occ_s < DEPTH_W);
    end

    // Fetch PC: restart on reset, jump on redirect, advance on each issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
        end else if (bus.redirect) begin
            fetch_pc_r <= bus.redirect_pc & ALIGN_MASK;
        end else if (issue_s) begin
            fetch_pc_r <= fetch_pc_r + PC_STEP;
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Track the single outstanding read; a flush forgets it so its data is dropped.
    always_ff @(posedge clk) begin
        if (rst || bus.redirect) begin
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= fetch_pc_r;
            end else begin
                inflight_pc_r <= inflight_pc_r;
            end
        end
    end

    // Queue bookkeeping: pointers and occupancy, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (rst || bus.redirect) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Capture the SRAM response together with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
            instr_mem_r[wr_ptr_r] <= bus.imem_rdata;
        end else begin
            pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
            instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
        end
    end

    assign bus.imem_req  = issue_s;
    assign bus.imem_addr = fetch_pc_r[IADDR_W+1:2];
    assign bus.valid_out = head_valid_s;
    assign bus.pc_out    = head_pc_s;
    assign bus.pc4_out   = head_pc4_s;
    assign bus.instr_out = head_instr_s;
    assign bus.count_out = count_r;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: three instances (DEPTH 4, 2, 16) share one
// stimulus stream and are each checked every cycle against a queue model that
// treats the prefetch queue as a contiguous run of PCs starting at a head PC.
module tb_if_prefetch_stage;
    localparam int XLEN    = 32;
    localparam int IADDR_W = 14;
    localparam int NDUT    = 3;

    function automatic int depth_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 2 : 16);
    endfunction

    // SRAM contents: word[n] = n + 0x100
    function automatic logic [31:0] mem_word(input logic [IADDR_W-1:0] a);
        return 32'(a) + 32'h100;
    endfunction

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;

    logic        o_valid [NDUT];
    logic [31:0] o_pc    [NDUT];
    logic [31:0] o_pc4   [NDUT];
    logic [31:0] o_instr [NDUT];
    logic [7:0]  o_count [NDUT];
    logic        o_req   [NDUT];
    logic [13:0] o_addr  [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int D = depth_of(g);
        logic [XLEN-1:0] rdata_r;

        if_prefetch_stage_if #(.XLEN(XLEN), .IADDR_W(IADDR_W), .DEPTH(D)) bus ();

        assign bus.redirect    = redirect;
        assign bus.redirect_pc = redirect_pc;
        assign bus.stall       = stall;
        assign bus.imem_rdata  = rdata_r;

        if_prefetch_stage #(
            .XLEN(XLEN), .IADDR_W(IADDR_W), .DEPTH(D), .RESET_PC(32'h0)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Synchronous SRAM with one cycle of read latency; garbage when idle.
        always @(posedge clk) begin
            rdata_r <= bus.imem_req ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
        end

        assign o_valid[g] = bus.valid_out;
        assign o_pc[g]    = bus.pc_out;
        assign o_pc4[g]   = bus.pc4_out;
        assign o_instr[g] = bus.instr_out;
        assign o_count[g] = 8'(bus.count_out);
        assign o_req[g]   = bus.imem_req;
        assign o_addr[g]  = bus.imem_addr;

        // A push into a full queue without a matching pop must never happen.
        always @(negedge clk) begin
            if (!rst) begin
                a_no_overflow: assert (!(dut.push_s && !dut.pop_s && int'(dut.count_r) == D))
                    else $error("FAIL overflow_assert dut%0d depth %0d", g, D);
            end
        end
    end

    // Reference model state per instance
    int          m_cnt   [NDUT];
    bit          m_infl  [NDUT];
    logic [31:0] m_head  [NDUT];
    logic [31:0] m_ipc   [NDUT];
    logic [31:0] m_fetch [NDUT];

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d (depth %0d) t=%0t: got %h, expected %h",
                     name, g, depth_of(g), $time, act, exp);
        end
    endtask

    function automatic bit m_pop(input int g);
        return (m_cnt[g] != 0) && !stall && !redirect;
    endfunction

    function automatic bit m_req(input int g);
        int occ;
        occ = m_cnt[g] + (m_infl[g] ? 1 : 0) - (m_pop(g) ? 1 : 0);
        return !rst && !redirect && (occ < depth_of(g));
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NDUT; g++) begin
            m_cnt[g]   = 0;
            m_infl[g]  = 1'b0;
            m_head[g]  = 32'h0;
            m_ipc[g]   = 32'h0;
            m_fetch[g] = 32'h0;
        end
    endtask

    task automatic model_check(input int g);
        bit          v;
        logic [31:0] epc;
        v   = (m_cnt[g] != 0);
        epc = v ? m_head[g] : 32'h0;
        chk("valid_out", g, 32'(o_valid[g]), 32'(v));
        chk("pc_out",    g, o_pc[g], epc);
        chk("pc4_out",   g, o_pc4[g], v ? (m_head[g] + 32'd4) : 32'h0);
        chk("instr_out", g, o_instr[g], v ? mem_word(m_head[g][15:2]) : 32'h0);
        chk("count_out", g, 32'(o_count[g]), 32'(m_cnt[g]));
        chk("imem_req",  g, 32'(o_req[g]), 32'(m_req(g)));
        chk("imem_addr", g, 32'(o_addr[g]), 32'(m_fetch[g][15:2]));
    endtask

    task automatic model_step(input int g);
        bit p;
        bit q;
        p = m_pop(g);
        q = m_req(g);
        if (rst) begin
            m_cnt[g]   = 0;
            m_infl[g]  = 1'b0;
            m_fetch[g] = 32'h0;
        end else if (redirect) begin
            m_cnt[g]   = 0;
            m_infl[g]  = 1'b0;
            m_fetch[g] = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (p) begin
                m_head[g] = m_head[g] + 32'd4;
                m_cnt[g]  = m_cnt[g] - 1;
            end
            if (m_infl[g]) begin
                if (m_cnt[g] == 0) m_head[g] = m_ipc[g];
                m_cnt[g] = m_cnt[g] + 1;
            end
            m_infl[g] = q;
            if (q) begin
                m_ipc[g]   = m_fetch[g];
                m_fetch[g] = m_fetch[g] + 32'd4;
            end
        end
    endtask

    // Drive inputs just after the rising edge, then check at the falling edge.
    task automatic apply(input bit r, input bit rd, input logic [31:0] rpc, input bit st);
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        stall       = st;
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) model_check(g);
    endtask

    task automatic advance();
        for (int g = 0; g < NDUT; g++) model_step(g);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          r;
        bit          rd;
        logic [31:0] rpc;
        bit          st;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] ei;
        int          ecnt;
        bit          ereq;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit rd, input logic [31:0] rpc, input bit st,
                                input bit ev, input logic [31:0] epc, input logic [31:0] ei,
                                input int ecnt, input bit ereq);
        vec_t v;
        v.r = r; v.rd = rd; v.rpc = rpc; v.st = st;
        v.ev = ev; v.epc = epc; v.ei = ei; v.ecnt = ecnt; v.ereq = ereq;
        return v;
    endfunction

    vec_t tbl [24];

    initial begin
        int stall_left;
        bit r;
        bit rd;
        bit st;
        logic [31:0] rpc;

        // Directed cycle table for the DEPTH=4 instance, starting from reset state:
        // fill, stall to full, release, redirect to 0x43 with 3 queued + 1 in flight,
        // redirect under stall, back-to-back redirects, 1-cycle rst mid-stream.
        tbl[0]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,   0, 1);
        tbl[1]  = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,   0, 1);
        tbl[2]  = mk(0, 0, 32'h0,  0, 1, 32'h0,  32'h100, 1, 1);
        tbl[3]  = mk(0, 0, 32'h0,  0, 1, 32'h4,  32'h101, 1, 1);
        tbl[4]  = mk(0, 0, 32'h0,  1, 1, 32'h8,  32'h102, 1, 1);
        tbl[5]  = mk(0, 0, 32'h0,  1, 1, 32'h8,  32'h102, 2, 1);
        tbl[6]  = mk(0, 0, 32'h0,  1, 1, 32'h8,  32'h102, 3, 0);
        tbl[7]  = mk(0, 0, 32'h0,  1, 1, 32'h8,  32'h102, 4, 0);
        tbl[8]  = mk(0, 0, 32'h0,  0, 1, 32'h8,  32'h102, 4, 1);
        tbl[9]  = mk(0, 0, 32'h0,  0, 1, 32'hC,  32'h103, 3, 1);
        tbl[10] = mk(0, 1, 32'h43, 0, 1, 32'h10, 32'h104, 3, 0);
        tbl[11] = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,   0, 1);
        tbl[12] = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,   0, 1);
        tbl[13] = mk(0, 0, 32'h0,  0, 1, 32'h40, 32'h110, 1, 1);
        tbl[14] = mk(0, 1, 32'h80, 1, 1, 32'h44, 32'h111, 1, 0);
        tbl[15] = mk(0, 1, 32'hC0, 0, 0, 32'h0,  32'h0,   0, 0);
        tbl[16] = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,   0, 1);
        tbl[17] = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,   0, 1);
        tbl[18] = mk(0, 0, 32'h0,  0, 1, 32'hC0, 32'h130, 1, 1);
        tbl[19] = mk(0, 0, 32'h0,  0, 1, 32'hC4, 32'h131, 1, 1);
        tbl[20] = mk(1, 0, 32'h0,  0, 1, 32'hC8, 32'h132, 1, 0);
        tbl[21] = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,   0, 1);
        tbl[22] = mk(0, 0, 32'h0,  0, 0, 32'h0,  32'h0,   0, 1);
        tbl[23] = mk(0, 0, 32'h0,  0, 1, 32'h0,  32'h100, 1, 1);

        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();

        // Held in reset: everything quiet
        apply(1, 0, 32'h0, 0);
        advance();

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].rd, tbl[i].rpc, tbl[i].st);
            chk("tbl_valid", 0, 32'(o_valid[0]), 32'(tbl[i].ev));
            chk("tbl_pc",    0, o_pc[0], tbl[i].epc);
            chk("tbl_pc4",   0, o_pc4[0], tbl[i].ev ? (tbl[i].epc + 32'd4) : 32'h0);
            chk("tbl_instr", 0, o_instr[0], tbl[i].ei);
            chk("tbl_count", 0, 32'(o_count[0]), 32'(tbl[i].ecnt));
            chk("tbl_req",   0, 32'(o_req[0]), 32'(tbl[i].ereq));
            advance();
        end

        // Long stall: shallow queues fill and stop requesting
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 32'h0, 1);
            if (i == 9) begin
                chk("stall_full_count", 0, 32'(o_count[0]), 32'd4);
                chk("stall_full_req",   0, 32'(o_req[0]), 32'd0);
                chk("stall_full_count", 1, 32'(o_count[1]), 32'd2);
                chk("stall_full_req",   1, 32'(o_req[1]), 32'd0);
            end
            advance();
        end
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, 32'h0, 0);
            advance();
        end

        // PC wrap at the top of the address space
        apply(0, 1, 32'hFFFF_FFF6, 0);
        advance();
        apply(0, 0, 32'h0, 0);
        chk("wrap_addr", 0, 32'(o_addr[0]), 32'h3FFD);
        advance();
        apply(0, 0, 32'h0, 0);
        advance();
        apply(0, 0, 32'h0, 0);
        chk("wrap_pc0", 0, o_pc[0], 32'hFFFF_FFF4);
        chk("wrap_instr0", 0, o_instr[0], 32'h40FD);
        advance();
        apply(0, 0, 32'h0, 0);
        advance();
        apply(0, 0, 32'h0, 0);
        chk("wrap_pc_top", 0, o_pc[0], 32'hFFFF_FFFC);
        chk("wrap_pc4_top", 0, o_pc4[0], 32'h0);
        chk("wrap_instr_top", 0, o_instr[0], 32'h40FF);
        advance();
        apply(0, 0, 32'h0, 0);
        chk("wrap_pc_zero", 0, o_pc[0], 32'h0);
        chk("wrap_instr_zero", 0, o_instr[0], 32'h100);
        advance();

        // Randomized traffic, every instance checked against the model each cycle
        stall_left = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            rd = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            else rpc = $urandom;
            if (stall_left > 0) begin
                stall_left--;
                st = 1'b1;
            end else if ($urandom_range(0, 9) == 0) begin
                stall_left = $urandom_range(1, 20);
                st = 1'b1;
            end else begin
                st = 1'b0;
            end
            apply(r, rd, rpc, st);
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
